// File: rtl/sram_arb_pkg.sv
// Shared definitions for the two-master asynchronous SRAM arbiter:
// FSM state encoding, master indices and timing defaults.
package sram_arb_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RD       = 3'd1;
    localparam logic [2:0] ST_WR_SETUP = 3'd2;
    localparam logic [2:0] ST_WR_PULSE = 3'd3;
    localparam logic [2:0] ST_WR_HOLD  = 3'd4;
    localparam logic [2:0] ST_ACK      = 3'd5;

    typedef enum logic [2:0] {
        StIdle    = ST_IDLE,
        StRd      = ST_RD,
        StWrSetup = ST_WR_SETUP,
        StWrPulse = ST_WR_PULSE,
        StWrHold  = ST_WR_HOLD,
        StAck     = ST_ACK
    } state_e;

    localparam logic M_CPU = 1'b0;
    localparam logic M_AUX = 1'b1;

    localparam int unsigned RD_CYCLES_DEF = 2;
    localparam int unsigned WR_CYCLES_DEF = 1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. On a tie the master that was not granted last wins;
// last grant resets to M_AUX so M_CPU wins the first tie.
module rr_arbiter2
    import sram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       update_i,
    output logic       gnt_valid_o,
    output logic       gnt_idx_o
);

    logic last_q;

    always_comb begin
        gnt_valid_o = |req_i;
        if (req_i == 2'b11) begin
            gnt_idx_o = ~last_q;
        end else if (req_i[1]) begin
            gnt_idx_o = M_AUX;
        end else begin
            gnt_idx_o = M_CPU;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= M_AUX;
        end else if (update_i && gnt_valid_o) begin
            last_q <= gnt_idx_o;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one asynchronous SRAM bank between two req/ack masters. All SRAM pins and
// acks are registered; the FSM sequences ce/oe/we timing for reads and writes.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 20,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned RD_CYCLES = RD_CYCLES_DEF,
    parameter int unsigned WR_CYCLES = WR_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_W-1:0]     m0_addr,
    input  logic [DATA_W-1:0]     m0_wdata,
    input  logic [DATA_W/8-1:0]   m0_be,
    output logic                  m0_ack,
    output logic [DATA_W-1:0]     m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_W-1:0]     m1_addr,
    input  logic [DATA_W-1:0]     m1_wdata,
    input  logic [DATA_W/8-1:0]   m1_be,
    output logic                  m1_ack,
    output logic [DATA_W-1:0]     m1_rdata,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W/8-1:0]   ram_be_n,
    output logic                  ram_ce_n,
    output logic                  ram_oe_n,
    output logic                  ram_we_n,
    output logic [DATA_W-1:0]     ram_data_o,
    output logic                  ram_data_oe,
    input  logic [DATA_W-1:0]     ram_data_i
);

    localparam int unsigned BeW    = DATA_W / 8;
    localparam int unsigned MaxCyc = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
    localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic              owner_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [BeW-1:0]    ram_be_n_q;
    logic              ram_ce_n_q;
    logic              ram_oe_n_q;
    logic              ram_we_n_q;
    logic [DATA_W-1:0] ram_data_q;
    logic              ram_data_oe_q;
    logic              m0_ack_q;
    logic              m1_ack_q;
    logic [DATA_W-1:0] m0_rdata_q;
    logic [DATA_W-1:0] m1_rdata_q;

    logic              gnt_valid;
    logic              gnt_idx;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [BeW-1:0]    sel_be;

    rr_arbiter2 u_rr (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       ({m1_req, m0_req}),
        .update_i    (state_q == StIdle),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx)
    );

    always_comb begin
        sel_we    = (gnt_idx == M_AUX) ? m1_we    : m0_we;
        sel_addr  = (gnt_idx == M_AUX) ? m1_addr  : m0_addr;
        sel_wdata = (gnt_idx == M_AUX) ? m1_wdata : m0_wdata;
        sel_be    = (gnt_idx == M_AUX) ? m1_be    : m0_be;
    end

    // Outputs are loaded with the values for the state being entered, so every pin
    // changes on the same edge as the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            owner_q       <= M_CPU;
            ram_addr_q    <= '0;
            ram_be_n_q    <= '1;
            ram_ce_n_q    <= 1'b1;
            ram_oe_n_q    <= 1'b1;
            ram_we_n_q    <= 1'b1;
            ram_data_q    <= '0;
            ram_data_oe_q <= 1'b0;
            m0_ack_q      <= 1'b0;
            m1_ack_q      <= 1'b0;
            m0_rdata_q    <= '0;
            m1_rdata_q    <= '0;
        end else begin
            m0_ack_q <= 1'b0;
            m1_ack_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (gnt_valid) begin
                        owner_q    <= gnt_idx;
                        cnt_q      <= '0;
                        ram_addr_q <= sel_addr;
                        ram_be_n_q <= ~sel_be;
                        ram_ce_n_q <= 1'b0;
                        if (sel_we) begin
                            ram_data_q    <= sel_wdata;
                            ram_data_oe_q <= 1'b1;
                            state_q       <= StWrSetup;
                        end else begin
                            ram_oe_n_q <= 1'b0;
                            state_q    <= StRd;
                        end
                    end
                end
                StRd: begin
                    if (cnt_q == CntW'(RD_CYCLES - 1)) begin
                        if (owner_q == M_AUX) begin
                            m1_rdata_q <= ram_data_i;
                        end else begin
                            m0_rdata_q <= ram_data_i;
                        end
                        ram_ce_n_q <= 1'b1;
                        ram_oe_n_q <= 1'b1;
                        ram_be_n_q <= '1;
                        m0_ack_q   <= (owner_q == M_CPU);
                        m1_ack_q   <= (owner_q == M_AUX);
                        state_q    <= StAck;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StWrSetup: begin
                    ram_we_n_q <= 1'b0;
                    cnt_q      <= '0;
                    state_q    <= StWrPulse;
                end
                StWrPulse: begin
                    if (cnt_q == CntW'(WR_CYCLES - 1)) begin
                        ram_we_n_q <= 1'b1;
                        state_q    <= StWrHold;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StWrHold: begin
                    ram_ce_n_q    <= 1'b1;
                    ram_be_n_q    <= '1;
                    ram_data_oe_q <= 1'b0;
                    m0_ack_q      <= (owner_q == M_CPU);
                    m1_ack_q      <= (owner_q == M_AUX);
                    state_q       <= StAck;
                end
                // Turnaround cycle: pins idle, no grant.
                StAck: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign ram_addr    = ram_addr_q;
    assign ram_be_n    = ram_be_n_q;
    assign ram_ce_n    = ram_ce_n_q;
    assign ram_oe_n    = ram_oe_n_q;
    assign ram_we_n    = ram_we_n_q;
    assign ram_data_o  = ram_data_q;
    assign ram_data_oe = ram_data_oe_q;
    assign m0_ack      = m0_ack_q;
    assign m1_ack      = m1_ack_q;
    assign m0_rdata    = m0_rdata_q;
    assign m1_rdata    = m1_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: default-timing instance plus a RD=3/WR=2 instance,
// each attached to a small behavioural SRAM model.
module tb_sram_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Default instance
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [19:0] m0_addr = '0, m1_addr = '0;
    logic [31:0] m0_wdata = '0, m1_wdata = '0;
    logic [3:0]  m0_be = 4'hF, m1_be = 4'hF;
    logic        m0_ack, m1_ack;
    logic [31:0] m0_rdata, m1_rdata;
    logic [19:0] ram_addr;
    logic [3:0]  ram_be_n;
    logic        ram_ce_n, ram_oe_n, ram_we_n, ram_data_oe;
    logic [31:0] ram_data_o, ram_data_i;

    // Swept instance
    logic        s_m0_req = 1'b0, s_m0_we = 1'b0, s_m1_req = 1'b0, s_m1_we = 1'b0;
    logic [19:0] s_m0_addr = '0, s_m1_addr = '0;
    logic [31:0] s_m0_wdata = '0, s_m1_wdata = '0;
    logic [3:0]  s_m0_be = 4'hF, s_m1_be = 4'hF;
    logic        s_m0_ack, s_m1_ack;
    logic [31:0] s_m0_rdata, s_m1_rdata;
    logic [19:0] s_ram_addr;
    logic [3:0]  s_ram_be_n;
    logic        s_ram_ce_n, s_ram_oe_n, s_ram_we_n, s_ram_data_oe;
    logic [31:0] s_ram_data_o, s_ram_data_i;

    sram_arbiter u_dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_be(m0_be), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_be(m1_be), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .ram_addr(ram_addr), .ram_be_n(ram_be_n), .ram_ce_n(ram_ce_n),
        .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n), .ram_data_o(ram_data_o),
        .ram_data_oe(ram_data_oe), .ram_data_i(ram_data_i)
    );

    sram_arbiter #(.RD_CYCLES(3), .WR_CYCLES(2)) u_dut_sw (
        .clk(clk), .rst_n(rst_n),
        .m0_req(s_m0_req), .m0_we(s_m0_we), .m0_addr(s_m0_addr), .m0_wdata(s_m0_wdata),
        .m0_be(s_m0_be), .m0_ack(s_m0_ack), .m0_rdata(s_m0_rdata),
        .m1_req(s_m1_req), .m1_we(s_m1_we), .m1_addr(s_m1_addr), .m1_wdata(s_m1_wdata),
        .m1_be(s_m1_be), .m1_ack(s_m1_ack), .m1_rdata(s_m1_rdata),
        .ram_addr(s_ram_addr), .ram_be_n(s_ram_be_n), .ram_ce_n(s_ram_ce_n),
        .ram_oe_n(s_ram_oe_n), .ram_we_n(s_ram_we_n), .ram_data_o(s_ram_data_o),
        .ram_data_oe(s_ram_data_oe), .ram_data_i(s_ram_data_i)
    );

    // SRAM models: unwritten words return a fixed per-address pattern.
    logic [31:0] mem_a [256];
    logic        vld_a [256] = '{default: 1'b0};
    logic [31:0] mem_b [256];
    logic        vld_b [256] = '{default: 1'b0};

    function automatic logic [31:0] init_word(input logic [7:0] a);
        case (a)
            8'h10:   return 32'hDEADBEEF;
            8'h20:   return 32'hAABBCCDD;
            8'h40:   return 32'h11111111;
            8'h41:   return 32'h22222222;
            default: return {24'hC0DE00, a};
        endcase
    endfunction

    function automatic logic [31:0] peek_a(input logic [7:0] a);
        return vld_a[a] ? mem_a[a] : init_word(a);
    endfunction

    function automatic logic [31:0] peek_b(input logic [7:0] a);
        return vld_b[a] ? mem_b[a] : init_word(a);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be_n);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (!be_n[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    assign ram_data_i   = peek_a(ram_addr[7:0]);
    assign s_ram_data_i = peek_b(s_ram_addr[7:0]);

    always @(posedge clk) begin
        if (!ram_we_n && !ram_ce_n) begin
            mem_a[ram_addr[7:0]] <= merge(peek_a(ram_addr[7:0]), ram_data_o, ram_be_n);
            vld_a[ram_addr[7:0]] <= 1'b1;
        end
        if (!s_ram_we_n && !s_ram_ce_n) begin
            mem_b[s_ram_addr[7:0]] <= merge(peek_b(s_ram_addr[7:0]), s_ram_data_o, s_ram_be_n);
            vld_b[s_ram_addr[7:0]] <= 1'b1;
        end
    end

    logic overlap_seen = 1'b0;
    always @(negedge clk) begin
        if ((!ram_oe_n && ram_data_oe) || (!s_ram_oe_n && s_ram_data_oe)) overlap_seen <= 1'b1;
    end

    a_no_overlap: assert property (@(posedge clk) disable iff (!rst_n)
                                   !(!ram_oe_n && ram_data_oe));
    a_no_overlap_sw: assert property (@(posedge clk) disable iff (!rst_n)
                                      !(!s_ram_oe_n && s_ram_data_oe));

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({ram_ce_n, ram_oe_n, ram_we_n} !== 3'b111) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want 111", {ram_ce_n, ram_oe_n, ram_we_n});
        end
        vectors++;
        if (ram_be_n !== 4'hF || ram_data_oe !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_be_oe: got be_n=%h oe=%b want F 0", ram_be_n, ram_data_oe);
        end
        vectors++;
        if (ram_addr !== 20'h0 || ram_data_o !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_addr_data: got %h %h want 0 0", ram_addr, ram_data_o);
        end
        vectors++;
        if ({m0_ack, m1_ack} !== 2'b00 || m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_master: got ack=%b rd=%h/%h want 00 0/0",
                     {m0_ack, m1_ack}, m0_rdata, m1_rdata);
        end
        vectors++;
        if ({s_ram_ce_n, s_ram_oe_n, s_ram_we_n, s_ram_data_oe} !== 4'b1110) begin
            miscompares++;
            $display("FAIL reset_sweep_ctrl: got %b want 1110",
                     {s_ram_ce_n, s_ram_oe_n, s_ram_we_n, s_ram_data_oe});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_read();
        int ack_k = 0; int oe_low = 0; int doe = 0; int ce_low = 0;
        m0_we = 1'b0; m0_addr = 20'h00010; m0_be = 4'hF; m0_req = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (!ram_oe_n) oe_low++;
            if (!ram_ce_n) ce_low++;
            if (ram_data_oe) doe++;
            if (m0_ack) begin ack_k = k; m0_req = 1'b0; break; end
        end
        @(negedge clk);
        vectors++;
        if (ack_k != 3) begin
            miscompares++; $display("FAIL read_ack_cycle: got %0d want 3", ack_k);
        end
        vectors++;
        if (oe_low != 2 || ce_low != 2) begin
            miscompares++; $display("FAIL read_oe_ce_low: got %0d/%0d want 2/2", oe_low, ce_low);
        end
        vectors++;
        if (doe != 0) begin
            miscompares++; $display("FAIL read_data_oe: got %0d cycles want 0", doe);
        end
        vectors++;
        if (m0_rdata !== 32'hDEADBEEF || m1_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL read_rdata: got %h/%h want deadbeef/0", m0_rdata, m1_rdata);
        end
    endtask

    task automatic test_write();
        int ack_k = 0; int ce_low = 0; int we_low = 0; int we_first = 0;
        logic be_bad = 1'b0; logic data_bad = 1'b0; logic m0_seen = 1'b0;
        m1_we = 1'b1; m1_addr = 20'h00020; m1_wdata = 32'h12345678; m1_be = 4'b0101;
        m1_req = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (!ram_ce_n) begin
                ce_low++;
                if (ram_be_n !== 4'b1010) be_bad = 1'b1;
                if (ram_data_oe !== 1'b1 || ram_data_o !== 32'h12345678) data_bad = 1'b1;
            end
            if (!ram_we_n) begin
                we_low++;
                if (we_first == 0) we_first = k;
            end
            if (m0_ack) m0_seen = 1'b1;
            if (m1_ack) begin ack_k = k; m1_req = 1'b0; break; end
        end
        @(negedge clk);
        vectors++;
        if (ack_k != 4) begin
            miscompares++; $display("FAIL write_ack_cycle: got %0d want 4", ack_k);
        end
        vectors++;
        if (ce_low != 3 || we_low != 1 || we_first != 2) begin
            miscompares++;
            $display("FAIL write_timing: got ce=%0d we=%0d at %0d want 3 1 at 2",
                     ce_low, we_low, we_first);
        end
        vectors++;
        if (be_bad || data_bad) begin
            miscompares++; $display("FAIL write_be_data: got bad=%b%b want 00", be_bad, data_bad);
        end
        vectors++;
        if (peek_a(8'h20) !== 32'hAA34CC78) begin
            miscompares++; $display("FAIL write_mem: got %h want aa34cc78", peek_a(8'h20));
        end
        vectors++;
        if (m0_seen || m1_rdata !== 32'h0 || m0_rdata !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL write_side: got m0ack=%b rd=%h/%h want 0 deadbeef/0",
                     m0_seen, m0_rdata, m1_rdata);
        end
    endtask

    task automatic test_arbitration();
        int order[8] = '{default: -1};
        int exp_order[8] = '{0, 1, 0, 1, 0, 1, 0, 1};
        int n = 0; int c0 = 0; int c1 = 0; logic both = 1'b0;
        m0_we = 1'b0; m0_addr = 20'h00050; m0_be = 4'hF;
        m1_we = 1'b1; m1_addr = 20'h00060; m1_wdata = 32'h0BADF00D; m1_be = 4'hF;
        m0_req = 1'b1; m1_req = 1'b1;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (m0_ack && m1_ack) both = 1'b1;
            if (m0_ack && n < 8) begin
                order[n] = 0; n++; c0++;
                if (c0 == 4) m0_req = 1'b0;
            end
            if (m1_ack && n < 8) begin
                order[n] = 1; n++; c1++;
                if (c1 == 4) m1_req = 1'b0;
            end
            if (n == 8) break;
        end
        m0_req = 1'b0; m1_req = 1'b0;
        @(negedge clk);
        vectors++;
        if (n != 8 || both) begin
            miscompares++; $display("FAIL arb_count: got %0d acks overlap=%b want 8 0", n, both);
        end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (order[i] != exp_order[i]) begin
                miscompares++;
                $display("FAIL arb_order[%0d]: got M%0d want M%0d", i, order[i], exp_order[i]);
            end
        end
        vectors++;
        if (m0_rdata !== init_word(8'h50) || peek_a(8'h60) !== 32'h0BADF00D ||
            m1_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL arb_data: got rd0=%h mem=%h rd1=%h want %h 0badf00d 0",
                     m0_rdata, peek_a(8'h60), m1_rdata, init_word(8'h50));
        end
    endtask

    task automatic test_back_to_back();
        int acks[2] = '{0, 0}; int n = 0;
        m0_we = 1'b0; m0_addr = 20'h00040; m0_be = 4'hF; m0_req = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (m0_ack) begin
                acks[n] = k; n++;
                if (n == 1) begin
                    vectors++;
                    if (m0_rdata !== 32'h11111111) begin
                        miscompares++;
                        $display("FAIL b2b_first_data: got %h want 11111111", m0_rdata);
                    end
                    m0_addr = 20'h00041;
                end else begin
                    m0_req = 1'b0;
                    break;
                end
            end
        end
        m0_req = 1'b0;
        @(negedge clk);
        vectors++;
        if (acks[0] != 3 || acks[1] != 7) begin
            miscompares++;
            $display("FAIL b2b_ack_cycles: got %0d,%0d want 3,7", acks[0], acks[1]);
        end
        vectors++;
        if (m0_rdata !== 32'h22222222 || m1_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL b2b_rdata: got %h/%h want 22222222/0", m0_rdata, m1_rdata);
        end
    endtask

    task automatic test_reset_mid_write();
        int ack0 = 0; int ack1 = 0; logic ack_in_rst = 1'b0;
        m0_we = 1'b1; m0_addr = 20'h00030; m0_wdata = 32'h55AA55AA; m0_be = 4'hF;
        m0_req = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (ram_we_n !== 1'b0) begin
            miscompares++; $display("FAIL mid_pulse_we: got %b want 0", ram_we_n);
        end
        rst_n = 1'b0;
        m1_we = 1'b0; m1_addr = 20'h00041; m1_be = 4'hF; m1_req = 1'b1;
        #1;
        vectors++;
        if ({ram_we_n, ram_ce_n, ram_data_oe} !== 3'b110) begin
            miscompares++;
            $display("FAIL mid_async_reset: got we/ce/oe=%b want 110",
                     {ram_we_n, ram_ce_n, ram_data_oe});
        end
        repeat (2) begin
            @(negedge clk);
            if (m0_ack || m1_ack) ack_in_rst = 1'b1;
        end
        vectors++;
        if (ack_in_rst || peek_a(8'h30) !== init_word(8'h30)) begin
            miscompares++;
            $display("FAIL mid_dropped: got ack=%b mem=%h want 0 %h",
                     ack_in_rst, peek_a(8'h30), init_word(8'h30));
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (m0_ack) begin ack0 = k; m0_req = 1'b0; end
            if (m1_ack) begin ack1 = k; m1_req = 1'b0; break; end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        @(negedge clk);
        vectors++;
        if (ack0 != 4 || ack1 != 8) begin
            miscompares++; $display("FAIL post_reset_grant: got %0d,%0d want 4,8", ack0, ack1);
        end
        vectors++;
        if (peek_a(8'h30) !== 32'h55AA55AA || m1_rdata !== 32'h22222222) begin
            miscompares++;
            $display("FAIL post_reset_data: got mem=%h rd1=%h want 55aa55aa 22222222",
                     peek_a(8'h30), m1_rdata);
        end
    endtask

    task automatic test_param_sweep();
        int ack_k = 0; int ce_low = 0; int we_low = 0;
        s_m0_we = 1'b0; s_m0_addr = 20'h00010; s_m0_be = 4'hF; s_m0_req = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (s_m0_ack) begin ack_k = k; s_m0_req = 1'b0; break; end
        end
        @(negedge clk);
        vectors++;
        if (ack_k != 4 || s_m0_rdata !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL sweep_read: got cycle %0d data %h want 4 deadbeef", ack_k, s_m0_rdata);
        end
        ack_k = 0;
        s_m1_we = 1'b1; s_m1_addr = 20'h00022; s_m1_wdata = 32'hCAFEF00D; s_m1_be = 4'hF;
        s_m1_req = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (!s_ram_ce_n) ce_low++;
            if (!s_ram_we_n) we_low++;
            if (s_m1_ack) begin ack_k = k; s_m1_req = 1'b0; break; end
        end
        @(negedge clk);
        vectors++;
        if (ack_k != 5 || ce_low != 4 || we_low != 2) begin
            miscompares++;
            $display("FAIL sweep_write: got ack %0d ce %0d we %0d want 5 4 2",
                     ack_k, ce_low, we_low);
        end
        vectors++;
        if (peek_b(8'h22) !== 32'hCAFEF00D) begin
            miscompares++; $display("FAIL sweep_mem: got %h want cafef00d", peek_b(8'h22));
        end
        vectors++;
        if (overlap_seen) begin
            miscompares++; $display("FAIL oe_overlap: got 1 want 0");
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_arbitration();
        test_back_to_back();
        test_reset_mid_write();
        test_param_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
